// File: rtl/piso_serializer_8b_pkg.sv
// Shared constants and state encoding for the 8-bit parallel-in/serial-out stage.
package piso_serializer_8b_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SEL_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_serializer_8b_bit_select_mux.sv
// Combinational WIDTH:1 bit select: presents word[sel] as the serial bit.
module piso_serializer_8b_bit_select_mux
  import piso_serializer_8b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [SEL_W-1:0] sel,
  output logic             ser_data
);

  assign ser_data = word[sel];

endmodule

// File: rtl/piso_serializer_8b.sv
// Parallel-in/serial-out stage: holds an accepted word and walks a select index
// LSB-first over it, with back-to-back loading on the last bit transfer.
module piso_serializer_8b
  import piso_serializer_8b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] word,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] sel_nxt_s;
  logic [WIDTH-1:0] word_r;
  logic [WIDTH-1:0] word_nxt_s;
  logic             on_last_s;
  logic             in_ready_s;
  logic             load_s;
  logic             bit_xfer_s;

  assign on_last_s  = (state_r == ST_SHIFT) && (sel_r == SEL_LAST);
  // Ready only when idle, or when the final bit leaves this very cycle.
  assign in_ready_s = !rst && ((state_r == ST_IDLE) || (on_last_s && ser_ready));
  assign load_s     = in_valid && in_ready_s;
  assign bit_xfer_s = (state_r == ST_SHIFT) && ser_ready;

  assign in_ready  = in_ready_s;
  assign sel       = sel_r;
  assign word      = word_r;
  assign ser_valid = (state_r == ST_SHIFT);
  assign busy      = (state_r == ST_SHIFT);
  assign ser_first = ser_valid && (sel_r == SEL_ZERO);
  assign ser_last  = ser_valid && (sel_r == SEL_LAST);

  piso_serializer_8b_bit_select_mux #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_bit_select_mux (
    .word     (word_r),
    .sel      (sel_r),
    .ser_data (ser_data)
  );

  // Next-state, select and word-hold decisions.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    word_nxt_s  = word_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s) begin
          word_nxt_s  = in_data;
          sel_nxt_s   = SEL_ZERO;
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!bit_xfer_s) begin
          state_nxt_s = ST_SHIFT;
        end else if (sel_r != SEL_LAST) begin
          sel_nxt_s = sel_r + SEL_ONE;
        end else if (load_s) begin
          word_nxt_s = in_data;
          sel_nxt_s  = SEL_ZERO;
        end else begin
          sel_nxt_s   = SEL_ZERO;
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        sel_nxt_s   = SEL_ZERO;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, select and word registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sel_r   <= SEL_ZERO;
      word_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
      word_r  <= word_nxt_s;
    end
  end

endmodule

// File: tb/tb_piso_serializer_8b.sv
// Directed bench for piso_serializer_8b: a per-cycle vector table plus
// hand-written backpressure, busy-input, last-bit-stall and mid-word reset sequences.
module tb_piso_serializer_8b;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [7:0] word;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_first;
  logic       ser_last;
  logic       busy;

  int checks;
  int errors;

  piso_serializer_8b dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .word      (word),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] din;
    logic       sr;
    logic       rdy;
    logic       sv;
    logic       sd;
    logic [2:0] sel;
    logic       first;
    logic       last;
    logic       busy;
    logic [7:0] word;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic [7:0] din, input logic sr,
                     input logic rdy, input logic sv, input logic sd, input logic [2:0] s,
                     input logic f, input logic l, input logic b, input logic [7:0] w);
    vec_t v;
    v.rst = r; v.iv = iv; v.din = din; v.sr = sr;
    v.rdy = rdy; v.sv = sv; v.sd = sd; v.sel = s;
    v.first = f; v.last = l; v.busy = b; v.word = w;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs mid-cycle and let combinational outputs settle.
  task automatic cyc(input logic r, input logic iv, input logic [7:0] din, input logic sr);
    @(negedge clk);
    rst = r; in_valid = iv; in_data = din; ser_ready = sr;
    #1;
  endtask

  initial begin
    logic [7:0] w19;
    logic [7:0] wa5;
    logic [7:0] w3c;
    logic [7:0] wf0;
    logic [7:0] w0f;
    logic [7:0] w81;
    w19 = 8'h19; wa5 = 8'hA5; w3c = 8'h3C;
    wf0 = 8'hF0; w0f = 8'h0F; w81 = 8'h81;
    checks = 0;
    errors = 0;

    // Basic single word 0x19: bits 1,0,0,1,1,0,0,0
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b1, 8'h19, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b0, 8'h00, 1'b1, (k == 7), 1'b1, w19[k], 3'(k), (k == 0), (k == 7), 1'b1, 8'h19);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h19);
    // Back-to-back 0xA5 then 0x3C with in_valid held; 0x3C offered throughout 0xA5
    add(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h19);
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b1, 8'h3C, 1'b1, (k == 7), 1'b1, wa5[k], 3'(k), (k == 0), (k == 7), 1'b1, 8'hA5);
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b0, 8'h00, 1'b1, (k == 7), 1'b1, w3c[k], 3'(k), (k == 0), (k == 7), 1'b1, 8'h3C);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h3C);

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ser_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].sr);
      chk($sformatf("v%0d in_ready", i), {7'd0, in_ready}, {7'd0, vecs[i].rdy});
      chk($sformatf("v%0d ser_valid", i), {7'd0, ser_valid}, {7'd0, vecs[i].sv});
      if (vecs[i].sv)
        chk($sformatf("v%0d ser_data", i), {7'd0, ser_data}, {7'd0, vecs[i].sd});
      chk($sformatf("v%0d sel", i), {5'd0, sel}, {5'd0, vecs[i].sel});
      chk($sformatf("v%0d ser_first", i), {7'd0, ser_first}, {7'd0, vecs[i].first});
      chk($sformatf("v%0d ser_last", i), {7'd0, ser_last}, {7'd0, vecs[i].last});
      chk($sformatf("v%0d busy", i), {7'd0, busy}, {7'd0, vecs[i].busy});
      chk($sformatf("v%0d word", i), word, vecs[i].word);
    end

    // Backpressure: 0xF0 stalled for 3 cycles at sel=2
    cyc(1'b0, 1'b1, 8'hF0, 1'b1);
    chk("bp load ready", {7'd0, in_ready}, 8'h01);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        for (int s = 0; s < 3; s++) begin
          cyc(1'b0, 1'b0, 8'h00, 1'b0);
          chk("bp stall sel", {5'd0, sel}, 8'h02);
          chk("bp stall valid", {7'd0, ser_valid}, 8'h01);
          chk("bp stall data", {7'd0, ser_data}, 8'h00);
          chk("bp stall ready", {7'd0, in_ready}, 8'h00);
        end
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("bp sel", {5'd0, sel}, 8'(k));
      chk("bp data", {7'd0, ser_data}, {7'd0, wf0[k]});
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("bp done busy", {7'd0, busy}, 8'h00);

    // Input ignored while busy, then last bit held with ser_ready low
    cyc(1'b0, 1'b1, 8'h0F, 1'b1);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b1, 8'hFF, 1'b1);
      chk("busy in_ready", {7'd0, in_ready}, 8'h00);
      chk("busy word", word, 8'h0F);
      chk("busy data", {7'd0, ser_data}, {7'd0, w0f[k]});
    end
    for (int s = 0; s < 2; s++) begin
      cyc(1'b0, 1'b1, 8'hFF, 1'b0);
      chk("last stall ready", {7'd0, in_ready}, 8'h00);
      chk("last stall sel", {5'd0, sel}, 8'h07);
      chk("last stall word", word, 8'h0F);
    end
    cyc(1'b0, 1'b1, 8'hFF, 1'b1);
    chk("last release ready", {7'd0, in_ready}, 8'h01);
    chk("last release data", {7'd0, ser_data}, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("reload word", word, 8'hFF);
    chk("reload first", {7'd0, ser_first}, 8'h01);
    chk("reload data", {7'd0, ser_data}, 8'h01);
    for (int k = 1; k < 8; k++)
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ff done busy", {7'd0, busy}, 8'h00);

    // Reset mid-word at sel=4 of 0x81
    cyc(1'b0, 1'b1, 8'h81, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("rst pre data", {7'd0, ser_data}, {7'd0, w81[k]});
    end
    cyc(1'b1, 1'b1, 8'h55, 1'b1);
    chk("rst sel4", {5'd0, sel}, 8'h04);
    chk("rst forces ready low", {7'd0, in_ready}, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post rst valid", {7'd0, ser_valid}, 8'h00);
    chk("post rst sel", {5'd0, sel}, 8'h00);
    chk("post rst word", word, 8'h00);
    chk("post rst busy", {7'd0, busy}, 8'h00);
    chk("post rst ready", {7'd0, in_ready}, 8'h01);
    chk("post rst first", {7'd0, ser_first}, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post rst no bits", {7'd0, ser_valid}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer_8b.md
Name: piso_serializer_8b

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the 8:1 bit-select mux datapath.
- Accepts an 8-bit word over a valid/ready handshake and holds it stable.
- Steps a 3-bit select index 0..7, one bit per accepted serial beat, and presents the selected bit LSB-first with first/last markers.
- Supports back-to-back words with no bubble and downstream backpressure.

Parameters:
- WIDTH, 8, parallel word width; must be a power of two and at least 2.
- SEL_W, 3, select/index width; equals log2(WIDTH) and is fixed by WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_data  input  WIDTH  parallel word; captured when in_valid && in_ready.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- sel  output  SEL_W  current bit index, driven to the mux select.
- word  output  WIDTH  held word, driven to the mux data input.
- ser_data  output  1  word[sel], the serial bit.
- ser_valid  output  1  ser_data is valid.
- ser_ready  input  1  downstream accepts the bit.
- ser_first  output  1  high when sel==0 and ser_valid.
- ser_last  output  1  high when sel==WIDTH-1 and ser_valid.
- busy  output  1  high while in the SHIFT state.

Behaviour:
- States:
  - IDLE: no word held.
  - SHIFT: a word is held and sel indexes the current bit.
- Reset (rst high at the edge):
  - state=IDLE, sel=0, word=0, ser_valid=0, busy=0.
  - in_ready is forced 0 during any cycle in which rst is high.
  - Reset overrides all other events, including reset mid-word. The partial word is discarded and no further bits are emitted.
- Definitions:
  - bit_xfer = ser_valid && ser_ready.
  - in_ready = !rst && (state==IDLE || (state==SHIFT && sel==WIDTH-1 && ser_ready)).
  - Load = in_valid && in_ready.
- IDLE:
  - On Load: word<=in_data, sel<=0, go to SHIFT.
  - Otherwise remain in IDLE; word retains its last value.
- SHIFT:
  - ser_valid=1 and ser_data=word[sel]; these are combinational from registered word and sel.
  - bit_xfer with sel<WIDTH-1: sel<=sel+1.
  - bit_xfer with sel==WIDTH-1 and in_valid: back-to-back case. Load the new word and set sel<=0; remain in SHIFT. There is no idle cycle between words.
  - bit_xfer with sel==WIDTH-1 and !in_valid: go to IDLE; sel<=0.
  - No bit_xfer (ser_ready=0): hold sel, word and all outputs stable. in_ready stays 0 unless the block is on the last bit with ser_ready=1.
- Latency: a word accepted at edge N has bit0 valid in the cycle after edge N. With ser_ready held high, bit k is transferred at edge N+1+k.
- Throughput: one word per WIDTH cycles at full rate.
- sel arithmetic is SEL_W-bit unsigned. The increment never wraps past WIDTH-1 because of the explicit last-bit transition.
- in_data is ignored whenever in_ready=0; the held word must never change mid-word.
- ser_first and ser_last are both gated by ser_valid, so both are 0 in IDLE.

Decomposition:
- Shared constants header holds WIDTH/SEL_W defaults and the state encodings: ST_IDLE=1'b0, ST_SHIFT=1'b1.
- One natural sub-module: bit_select_mux, a combinational WIDTH:1 select producing ser_data from word and sel.
- The FSM, sel counter and word register stay in the top module.

Test Plan:
- Basic single word: rst for 2 cycles, then in_data=8'b00011001 with in_valid for 1 cycle, ser_ready=1. ser_data sequence is 1,0,0,1,1,0,0,0 on sel 0..7. ser_first is high only at sel=0 and ser_last only at sel=7. The block returns to IDLE with busy=0 after 8 transfers.
- Back-to-back: 8'hA5 then 8'h3C, with in_valid held high. Expected 16 consecutive valid bits: 1,0,1,0,0,1,0,1 followed by 0,0,1,1,1,1,0,0. in_ready pulses exactly at sel=7 of the first word; there is no bubble.
- Backpressure: 8'hF0 with ser_ready=0 during sel=2 for 3 cycles. sel, ser_data=0 and ser_valid=1 hold steady. Sequence completes 0,0,0,0,1,1,1,1 with no skipped or repeated bit.
- Input ignored while busy: during SHIFT of 8'h0F, drive in_valid=1 with in_data=8'hFF. in_ready=0 until sel=7; word stays 8'h0F; the second word is loaded only at the last-bit transfer.
- Reset mid-word: assert rst at sel=4 of 8'h81. The next cycle shows state IDLE, sel=0, ser_valid=0 and word=0, with no further bits. in_ready=1 the first cycle after rst deasserts.
- Last bit with ser_ready low: hold ser_ready=0 at sel=7 with in_valid=1. in_ready must stay 0 and no load may occur until ser_ready rises.
